lockstep_comparator: RTL and testbench

Parametrised N-way lockstep comparator and majority voter for redundant peripheral instances (e.g. duplicated or triplicated AHB VGA datapaths) sharing one bus and clock. Each cycle it samples CHANNELS copies of a WIDTH-bit observation vector and produces a registered voted output, per-channel disagreement flags and a mismatch strobe. It filters transient disagreements through a persistence threshold into a sticky FAULT, and keeps a saturating error count plus a sticky per-channel fault mask for the system monitor.

---
 rtl/lockstep_comparator.sv | 128 ++++++++++++
 tb/tb_lockstep_comparator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lockstep_comparator.sv
// N-way lockstep comparator / majority voter with persistence-filtered sticky fault.
// Latency: 1 cycle from DIN to DOUT, MISMATCH, CH_FAULT, FAULT_MASK, ERR_COUNT and FAULT.
// Backpressure: none; DIN is sampled on every rising HCLK edge.
//
// Ports:
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   EN              compare enable (DOUT follows the vote regardless)
//   CLR             synchronous clear of FAULT, FAULT_MASK, ERR_COUNT and run counter
//   DIN             CHANNELS packed observations, channel c at DIN[c*WIDTH +: WIDTH]
//   DOUT            registered voted vector
//   MISMATCH        registered: any channel disagreed with the vote
//   CH_FAULT        registered per-channel disagreement flags
//   FAULT           sticky flag after THRESHOLD consecutive enabled mismatch cycles
//   FAULT_MASK      sticky OR of per-channel disagreements
//   ERR_COUNT       saturating count of enabled mismatch cycles
module lockstep_comparator #(
    parameter int WIDTH     = 42,
    parameter int CHANNELS  = 2,
    parameter int THRESHOLD = 1,
    parameter int CNT_W     = 8
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic                         EN,
    input  logic                         CLR,
    input  logic [CHANNELS*WIDTH-1:0]    DIN,
    output logic [WIDTH-1:0]             DOUT,
    output logic                         MISMATCH,
    output logic [CHANNELS-1:0]          CH_FAULT,
    output logic                         FAULT,
    output logic [CHANNELS-1:0]          FAULT_MASK,
    output logic [CNT_W-1:0]             ERR_COUNT
);

    localparam int              RUN_W   = $clog2(THRESHOLD + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(THRESHOLD);

    logic [WIDTH-1:0]    vote;
    logic [CHANNELS-1:0] raw_fault;
    logic                raw_mm;
    logic [RUN_W-1:0]    run_cnt;
    logic [RUN_W-1:0]    run_next;

    // Strict majority wins; an exact tie (even channel count) defers to
    // channel 0, which also makes the two-channel case simply follow channel 0.
    function automatic logic vote_bit(input logic [CHANNELS-1:0] bits);
        int ones;
        ones = 0;
        for (int c = 0; c < CHANNELS; c++) begin
            ones = ones + (bits[c] ? 1 : 0);
        end
        if (2 * ones > CHANNELS) begin
            return 1'b1;
        end
        if (2 * ones == CHANNELS) begin
            return bits[0];
        end
        return 1'b0;
    endfunction

    always_comb begin : vote_logic
        logic [CHANNELS-1:0] col;
        col  = '0;
        vote = '0;
        for (int b = 0; b < WIDTH; b++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                col[c] = DIN[c*WIDTH + b];
            end
            vote[b] = vote_bit(col);
        end
    end

    always_comb begin
        raw_fault = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            raw_fault[c] = EN && (DIN[c*WIDTH +: WIDTH] != vote);
        end
    end

    assign raw_mm = |raw_fault;

    // Disabled cycles freeze the run so EN gaps neither break nor extend it.
    always_comb begin
        run_next = run_cnt;
        if (EN) begin
            if (raw_mm) begin
                if (run_cnt != RUN_MAX) begin
                    run_next = run_cnt + 1'b1;
                end
            end else begin
                run_next = '0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            DOUT       <= '0;
            MISMATCH   <= 1'b0;
            CH_FAULT   <= '0;
            FAULT      <= 1'b0;
            FAULT_MASK <= '0;
            ERR_COUNT  <= '0;
            run_cnt    <= '0;
        end else begin
            DOUT     <= vote;
            CH_FAULT <= raw_fault;
            MISMATCH <= raw_mm;
            // A mismatch seen in the clear cycle is reported but not accumulated.
            if (CLR) begin
                FAULT      <= 1'b0;
                FAULT_MASK <= '0;
                ERR_COUNT  <= '0;
                run_cnt    <= '0;
            end else begin
                run_cnt    <= run_next;
                FAULT_MASK <= FAULT_MASK | raw_fault;
                if (run_next == RUN_MAX) begin
                    FAULT <= 1'b1;
                end
                if (raw_mm && (ERR_COUNT != '1)) begin
                    ERR_COUNT <= ERR_COUNT + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lockstep_comparator.sv
// Bench for lockstep_comparator: three configurations driven with directed vectors.
// Expected outputs are queued at stimulus time and checked one cycle later by a monitor.
// Reset expectations are checked in the same cycle reset is asserted.
module tb_lockstep_comparator;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;

    // Instance 0: WIDTH=8, CHANNELS=3, THRESHOLD=4, CNT_W=8
    logic        en0, clr0;
    logic [23:0] din0;
    logic [7:0]  dout0;
    logic        mm0;
    logic [2:0]  chf0;
    logic        fault0;
    logic [2:0]  mask0;
    logic [7:0]  cnt0;

    // Instance 1: WIDTH=8, CHANNELS=2, THRESHOLD=1, CNT_W=2
    logic        en1, clr1;
    logic [15:0] din1;
    logic [7:0]  dout1;
    logic        mm1;
    logic [1:0]  chf1;
    logic        fault1;
    logic [1:0]  mask1;
    logic [1:0]  cnt1;

    // Instance 2: WIDTH=8, CHANNELS=4, THRESHOLD=2, CNT_W=8
    logic        en2, clr2;
    logic [31:0] din2;
    logic [7:0]  dout2;
    logic        mm2;
    logic [3:0]  chf2;
    logic        fault2;
    logic [3:0]  mask2;
    logic [7:0]  cnt2;

    lockstep_comparator #(.WIDTH(8), .CHANNELS(3), .THRESHOLD(4), .CNT_W(8)) u0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .EN(en0), .CLR(clr0), .DIN(din0),
        .DOUT(dout0), .MISMATCH(mm0), .CH_FAULT(chf0), .FAULT(fault0),
        .FAULT_MASK(mask0), .ERR_COUNT(cnt0)
    );

    lockstep_comparator #(.WIDTH(8), .CHANNELS(2), .THRESHOLD(1), .CNT_W(2)) u1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .EN(en1), .CLR(clr1), .DIN(din1),
        .DOUT(dout1), .MISMATCH(mm1), .CH_FAULT(chf1), .FAULT(fault1),
        .FAULT_MASK(mask1), .ERR_COUNT(cnt1)
    );

    lockstep_comparator #(.WIDTH(8), .CHANNELS(4), .THRESHOLD(2), .CNT_W(8)) u2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .EN(en2), .CLR(clr2), .DIN(din2),
        .DOUT(dout2), .MISMATCH(mm2), .CH_FAULT(chf2), .FAULT(fault2),
        .FAULT_MASK(mask2), .ERR_COUNT(cnt2)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        int         inst;
        int         due;
        int         id;
        logic [7:0] dout;
        logic       mm;
        logic [3:0] chf;
        logic       fault;
        logic [3:0] mask;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   vec_id = 0;

    function automatic exp_t actual_of(input int inst);
        exp_t a;
        a.inst = inst;
        a.due = 0;
        a.id = 0;
        case (inst)
            0: begin
                a.dout = dout0; a.mm = mm0; a.chf = {1'b0, chf0}; a.fault = fault0;
                a.mask = {1'b0, mask0}; a.cnt = cnt0;
            end
            1: begin
                a.dout = dout1; a.mm = mm1; a.chf = {2'b0, chf1}; a.fault = fault1;
                a.mask = {2'b0, mask1}; a.cnt = {6'b0, cnt1};
            end
            default: begin
                a.dout = dout2; a.mm = mm2; a.chf = chf2; a.fault = fault2;
                a.mask = mask2; a.cnt = cnt2;
            end
        endcase
        return a;
    endfunction

    task automatic push(input int inst, input int due, input logic [7:0] dout, input logic mm,
                        input logic [3:0] chf, input logic fault, input logic [3:0] mask,
                        input logic [7:0] cnt);
        exp_t e;
        e.inst = inst; e.due = due; e.id = vec_id;
        e.dout = dout; e.mm = mm; e.chf = chf; e.fault = fault; e.mask = mask; e.cnt = cnt;
        vec_id++;
        q.push_back(e);
    endtask

    // Drive one instance for one cycle and queue what it must show after the edge.
    task automatic step(input int inst, input logic en, input logic clr, input logic [31:0] din,
                        input logic [7:0] dout, input logic mm, input logic [3:0] chf,
                        input logic fault, input logic [3:0] mask, input logic [7:0] cnt);
        logic [31:0] d;
        d = din;
        case (inst)
            0:       begin en0 = en; clr0 = clr; din0 = d[23:0]; end
            1:       begin en1 = en; clr1 = clr; din1 = d[15:0]; end
            default: begin en2 = en; clr2 = clr; din2 = d; end
        endcase
        push(inst, cyc + 1, dout, mm, chf, fault, mask, cnt);
        @(posedge HCLK);
        #1;
    endtask

    exp_t me, ma;
    always @(negedge HCLK) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            me = q.pop_front();
            ma = actual_of(me.inst);
            total++;
            if (me.due < cyc) begin
                bad++;
                $display("FAIL vec%0d inst%0d: check missed its cycle (due %0d, now %0d)",
                         me.id, me.inst, me.due, cyc);
            end else if ({ma.dout, ma.mm, ma.chf, ma.fault, ma.mask, ma.cnt} !==
                         {me.dout, me.mm, me.chf, me.fault, me.mask, me.cnt}) begin
                bad++;
                $display("FAIL vec%0d inst%0d: got dout=%h mm=%b chf=%b fault=%b mask=%b cnt=%0d, want dout=%h mm=%b chf=%b fault=%b mask=%b cnt=%0d",
                         me.id, me.inst, ma.dout, ma.mm, ma.chf, ma.fault, ma.mask, ma.cnt,
                         me.dout, me.mm, me.chf, me.fault, me.mask, me.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        en0 = 1'b0; clr0 = 1'b0; din0 = '0;
        en1 = 1'b0; clr1 = 1'b0; din1 = '0;
        en2 = 1'b0; clr2 = 1'b0; din2 = '0;
        HRESETn = 1'b0;

        @(posedge HCLK);
        #1;
        for (int i = 0; i < 3; i++) push(i, cyc, 8'h00, 1'b0, 4'b0, 1'b0, 4'b0, 8'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Three channels agreeing
        step(0, 1, 0, 24'hA5A5A5, 8'hA5, 0, 4'b0000, 0, 4'b0000, 8'd0);
        // Channel 2 off by one bit for three cycles: below threshold
        step(0, 1, 0, 24'hA4A5A5, 8'hA5, 1, 4'b0100, 0, 4'b0100, 8'd1);
        step(0, 1, 0, 24'hA4A5A5, 8'hA5, 1, 4'b0100, 0, 4'b0100, 8'd2);
        step(0, 1, 0, 24'hA4A5A5, 8'hA5, 1, 4'b0100, 0, 4'b0100, 8'd3);
        // Agreeing again, with clear
        step(0, 1, 1, 24'hA5A5A5, 8'hA5, 0, 4'b0000, 0, 4'b0000, 8'd0);
        // Channel 1 stuck at zero: two enabled, two disabled, two enabled
        step(0, 1, 0, 24'hA500A5, 8'hA5, 1, 4'b0010, 0, 4'b0010, 8'd1);
        step(0, 1, 0, 24'hA500A5, 8'hA5, 1, 4'b0010, 0, 4'b0010, 8'd2);
        step(0, 0, 0, 24'hA500A5, 8'hA5, 0, 4'b0000, 0, 4'b0010, 8'd2);
        step(0, 0, 0, 24'hA500A5, 8'hA5, 0, 4'b0000, 0, 4'b0010, 8'd2);
        step(0, 1, 0, 24'hA500A5, 8'hA5, 1, 4'b0010, 0, 4'b0010, 8'd3);
        step(0, 1, 0, 24'hA500A5, 8'hA5, 1, 4'b0010, 1, 4'b0010, 8'd4);
        // Clear while mismatch present: still reported, not accumulated
        step(0, 1, 1, 24'hA500A5, 8'hA5, 1, 4'b0010, 0, 4'b0000, 8'd0);
        // New run from zero
        step(0, 1, 0, 24'hA500A5, 8'hA5, 1, 4'b0010, 0, 4'b0010, 8'd1);
        step(0, 1, 0, 24'hA500A5, 8'hA5, 1, 4'b0010, 0, 4'b0010, 8'd2);
        step(0, 1, 0, 24'hA500A5, 8'hA5, 1, 4'b0010, 0, 4'b0010, 8'd3);
        step(0, 1, 0, 24'hA500A5, 8'hA5, 1, 4'b0010, 1, 4'b0010, 8'd4);
        step(0, 1, 0, 24'hA500A5, 8'hA5, 1, 4'b0010, 1, 4'b0010, 8'd5);
        en0 = 1'b0;

        // Two channels, threshold 1, 2-bit counter saturating at 3
        step(1, 1, 0, 32'h0000C33C, 8'h3C, 1, 4'b0010, 1, 4'b0010, 8'd1);
        step(1, 1, 0, 32'h0000C33C, 8'h3C, 1, 4'b0010, 1, 4'b0010, 8'd2);
        step(1, 1, 0, 32'h0000C33C, 8'h3C, 1, 4'b0010, 1, 4'b0010, 8'd3);
        step(1, 1, 0, 32'h0000C33C, 8'h3C, 1, 4'b0010, 1, 4'b0010, 8'd3);
        step(1, 1, 0, 32'h0000C33C, 8'h3C, 1, 4'b0010, 1, 4'b0010, 8'd3);
        en1 = 1'b0;

        // Four channels: 2-2 tie, 3-1 majority, per-bit mixed ties, agreement
        step(2, 1, 0, 32'h0000FFFF, 8'hFF, 1, 4'b1100, 0, 4'b1100, 8'd1);
        step(2, 1, 0, 32'hFFFFFF00, 8'hFF, 1, 4'b0001, 1, 4'b1101, 8'd2);
        step(2, 1, 0, 32'h00FF0FF0, 8'hF0, 1, 4'b1110, 1, 4'b1111, 8'd3);
        step(2, 1, 0, 32'h5A5A5A5A, 8'h5A, 0, 4'b0000, 1, 4'b1111, 8'd3);
        en2 = 1'b0;

        // Instance 0 has held its sticky state through the disabled cycles
        push(0, cyc, 8'hA5, 1'b0, 4'b0000, 1'b1, 4'b0010, 8'd5);
        @(posedge HCLK);
        #1;

        // Asynchronous reset mid-run: checked before any further clock edge
        HRESETn = 1'b0;
        for (int i = 0; i < 3; i++) push(i, cyc, 8'h00, 1'b0, 4'b0, 1'b0, 4'b0, 8'd0);
        @(posedge HCLK);
        #1;
        push(0, cyc, 8'h00, 1'b0, 4'b0, 1'b0, 4'b0, 8'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Fresh run needs the full threshold again
        step(0, 1, 0, 24'hA500A5, 8'hA5, 1, 4'b0010, 0, 4'b0010, 8'd1);
        step(0, 1, 0, 24'hA500A5, 8'hA5, 1, 4'b0010, 0, 4'b0010, 8'd2);
        step(0, 1, 0, 24'hA500A5, 8'hA5, 1, 4'b0010, 0, 4'b0010, 8'd3);
        step(0, 1, 0, 24'hA500A5, 8'hA5, 1, 4'b0010, 1, 4'b0010, 8'd4);

        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            @(posedge HCLK);
            #1;
        end
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected responses never checked, want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
